divide_by_n_fsm: RTL and testbench

- Parametrised successor to the fixed divide-by-4 Moore FSM: a counter-based FSM producing output y once every N enabled clock cycles.
- N is programmable at run time. Two output modes: single-cycle pulse, or near-50% square wave.
- Used as the shared clock-enable / tick generator feeding slower logic on the Basys3 designs (LED blinkers, display multiplexing, UART baud ticks).

---
 rtl/divide_by_n_fsm_pkg.sv | 11 +
 rtl/divide_by_n_fsm_if.sv | 26 ++
 rtl/divide_by_n_fsm.sv | 96 +++++++++
 tb/tb_divide_by_n_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/divide_by_n_fsm_pkg.sv
// Shared types and defaults for the programmable tick / clock-enable divider.
package divide_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } div_mode_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/divide_by_n_fsm_if.sv
// Control/status bundle of the divider: enable, restart, divisor load strobe and the divided output.
interface divide_by_n_fsm_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;
  logic             restart;
  logic [WIDTH-1:0] div_in;
  logic             mode_in;
  logic             div_load;
  logic             y;
  logic [WIDTH-1:0] cur_div;
  logic             cur_mode;
  logic             load_pending;

  modport master (
    output en, restart, div_in, mode_in, div_load,
    input  y, cur_div, cur_mode, load_pending
  );

  modport slave (
    input  en, restart, div_in, mode_in, div_load,
    output y, cur_div, cur_mode, load_pending
  );

endinterface

// File: rtl/divide_by_n_fsm.sv
// Divide-by-N tick generator: y high once per N enabled cycles (pulse) or ~50% duty (square).
// y is decoded from registered state with no added latency; new divisors take effect only at a period boundary.
module divide_by_n_fsm
  import divide_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(4),
  parameter bit               DEFAULT_MODE = 1'b0
) (
  input logic              clk,
  input logic              reset,
  divide_by_n_fsm_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  div_mode_t        cur_mode_q, cur_mode_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  div_mode_t        pend_mode_q, pend_mode_d;
  logic             pend_valid_q, pend_valid_d;

  logic [WIDTH-1:0] eff;
  logic             wrap;
  logic             boundary;

  // Square mode stays high for ceil(eff/2) counts; one extra bit so eff=2^WIDTH-1 does not overflow.
  function automatic logic [WIDTH:0] square_high_limit(input logic [WIDTH-1:0] e);
    return ({1'b0, e} + (WIDTH+1)'(1)) >> 1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      cur_div_q    <= DEFAULT_DIV;
      cur_mode_q   <= div_mode_t'(DEFAULT_MODE);
      pend_div_q   <= '0;
      pend_mode_q  <= MODE_PULSE;
      pend_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      cur_div_q    <= cur_div_d;
      cur_mode_q   <= cur_mode_d;
      pend_div_q   <= pend_div_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_comb begin
    count_d      = count_q;
    cur_div_d    = cur_div_q;
    cur_mode_d   = cur_mode_q;
    pend_div_d   = pend_div_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;

    eff      = (cur_div_q == '0) ? WIDTH'(1) : cur_div_q;
    wrap     = bus.en && (count_q == eff - WIDTH'(1));
    boundary = bus.restart || wrap;

    if (boundary) begin
      // A load on the boundary edge itself bypasses the pending slot.
      count_d = '0;
      if (bus.div_load) begin
        cur_div_d  = bus.div_in;
        cur_mode_d = div_mode_t'(bus.mode_in);
      end else if (pend_valid_q) begin
        cur_div_d  = pend_div_q;
        cur_mode_d = pend_mode_q;
      end
      pend_valid_d = 1'b0;
    end else begin
      if (bus.en) begin
        count_d = count_q + WIDTH'(1);
      end
      if (bus.div_load) begin
        pend_div_d   = bus.div_in;
        pend_mode_d  = div_mode_t'(bus.mode_in);
        pend_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    if (cur_mode_q == MODE_SQUARE) begin
      bus.y = ({1'b0, count_q} < square_high_limit(eff));
    end else begin
      bus.y = (count_q == '0);
    end
  end

  assign bus.cur_div      = cur_div_q;
  assign bus.cur_mode     = cur_mode_q;
  assign bus.load_pending = pend_valid_q;

endmodule

// File: tb/tb_divide_by_n_fsm.sv
// Self-checking bench for divide_by_n_fsm: directed period patterns plus randomized control traffic.
module tb_divide_by_n_fsm;

  logic clk;
  logic reset;

  divide_by_n_fsm_if #(.WIDTH(8)) bus ();

  divide_by_n_fsm #(
    .WIDTH       (8),
    .DEFAULT_DIV (8'd4),
    .DEFAULT_MODE(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: position within the current period plus the divisor/mode in force and any queued change.
  int m_pos, m_div, m_mode, m_pdiv, m_pmode;
  bit m_pv;

  function automatic int eff_of(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic exp_y();
    int e;
    e = eff_of(m_div);
    if (m_mode == 1) return (m_pos < (e + 1) / 2);
    return (m_pos == 0);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_div = 4; m_mode = 0; m_pv = 0; m_pdiv = 0; m_pmode = 0;
  endtask

  task automatic model_edge(input bit en, input bit rs, input bit ld, input int din, input bit mi);
    bit period_end;
    period_end = en && (m_pos == eff_of(m_div) - 1);
    if (rs || period_end) begin
      m_pos = 0;
      if (ld) begin m_div = din; m_mode = mi; end
      else if (m_pv) begin m_div = m_pdiv; m_mode = m_pmode; end
      m_pv = 0;
    end else begin
      if (en) m_pos = m_pos + 1;
      if (ld) begin m_pdiv = din; m_pmode = mi; m_pv = 1; end
    end
  endtask

  task automatic chk_model();
    chk("y_model", {31'd0, bus.y}, {31'd0, exp_y()});
    chk("cur_div_model", {24'd0, bus.cur_div}, m_div);
    chk("cur_mode_model", {31'd0, bus.cur_mode}, m_mode);
    chk("pending_model", {31'd0, bus.load_pending}, {31'd0, m_pv});
  endtask

  // Drive one edge's worth of inputs, advance the model, check just after the edge.
  task automatic step(input bit en, input bit rs, input bit ld, input int din, input bit mi);
    bus.en       = en;
    bus.restart  = rs;
    bus.div_load = ld;
    bus.div_in   = din[7:0];
    bus.mode_in  = mi;
    @(posedge clk);
    model_edge(en, rs, ld, din & 255, mi);
    #1;
    chk_model();
  endtask

  initial begin
    int highs;
    logic [4:0] p5;
    logic [5:0] p6;
    logic [6:0] en_seq;
    int din;

    reset = 1'b1;
    bus.en = 1'b0; bus.restart = 1'b0; bus.div_load = 1'b0;
    bus.div_in = '0; bus.mode_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_y", {31'd0, bus.y}, 32'd1);
    chk("reset_cur_div", {24'd0, bus.cur_div}, 32'd4);
    chk("reset_cur_mode", {31'd0, bus.cur_mode}, 32'd0);
    chk("reset_pending", {31'd0, bus.load_pending}, 32'd0);
    reset = 1'b0;

    // Default divide-by-4 pulse: 1,0,0,0 and 25 highs in 100 cycles.
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      chk("div4_pattern", {31'd0, bus.y}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (bus.y) highs++;
      step(1, 0, 0, 0, 0);
    end
    chk("div4_highs", highs, 32'd25);

    // Square mode, load then restart.
    step(1, 0, 1, 5, 1);
    step(1, 1, 0, 0, 0);
    p5 = 5'b11100;
    for (int i = 0; i < 10; i++) begin
      chk("square5", {31'd0, bus.y}, {31'd0, p5[4 - (i % 5)]});
      step(1, 0, 0, 0, 0);
    end
    step(1, 1, 1, 6, 1);
    p6 = 6'b111000;
    for (int i = 0; i < 12; i++) begin
      chk("square6", {31'd0, bus.y}, {31'd0, p6[5 - (i % 6)]});
      step(1, 0, 0, 0, 0);
    end

    // Load mid-period: current period completes before divisor 3 applies.
    step(1, 1, 1, 4, 0);
    chk("div4_start_y", {31'd0, bus.y}, 32'd1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 0);
    chk("midload_pending", {31'd0, bus.load_pending}, 32'd1);
    chk("midload_old_div", {24'd0, bus.cur_div}, 32'd4);
    chk("midload_y_c2", {31'd0, bus.y}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("midload_pending_c3", {31'd0, bus.load_pending}, 32'd1);
    chk("midload_y_c3", {31'd0, bus.y}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("midload_new_div", {24'd0, bus.cur_div}, 32'd3);
    chk("midload_cleared", {31'd0, bus.load_pending}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("div3_pattern", {31'd0, bus.y}, (i % 3 == 0) ? 32'd1 : 32'd0);
      step(1, 0, 0, 0, 0);
    end

    // Two loads in one period: last one wins.
    step(1, 0, 1, 7, 0);
    step(1, 0, 1, 2, 0);
    step(1, 0, 0, 0, 0);
    chk("last_load_wins", {24'd0, bus.cur_div}, 32'd2);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("div0_y_high", {31'd0, bus.y}, 32'd1);
      chk("div0_cur_div", {24'd0, bus.cur_div}, 32'd0);
      step(1, 0, 0, 0, 0);
    end

    // en low for 3 cycles at position 2 stretches this period to 7 clocks.
    step(1, 1, 1, 4, 0);
    en_seq = 7'b1100011;
    for (int k = 0; k < 7; k++) begin
      step(en_seq[6 - k], 0, 0, 0, 0);
      chk("en_gap", {31'd0, bus.y}, (k == 6) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 0);
      chk("en_normal", {31'd0, bus.y}, (k == 3) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset between edges at position 3 with a load pending.
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 9, 1);
    step(1, 0, 0, 0, 0);
    chk("pre_reset_y", {31'd0, bus.y}, 32'd0);
    chk("pre_reset_pending", {31'd0, bus.load_pending}, 32'd1);
    bus.div_load = 1'b0; bus.restart = 1'b0; bus.en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_reset_y", {31'd0, bus.y}, 32'd1);
    chk("async_reset_div", {24'd0, bus.cur_div}, 32'd4);
    chk("async_reset_pending", {31'd0, bus.load_pending}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step(0, 1, 1, 2, 0);
    chk("restart_load_div", {24'd0, bus.cur_div}, 32'd2);
    chk("restart_load_y", {31'd0, bus.y}, 32'd1);
    step(1, 0, 0, 0, 0);
    chk("div2_low", {31'd0, bus.y}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("div2_high", {31'd0, bus.y}, 32'd1);

    // Randomized control traffic against the reference.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 7) din = $urandom_range(0, 9);
      else din = $urandom_range(0, 255);
      step(($urandom_range(0, 9) < 8),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 19) == 0),
           din,
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
